sync_mem_be: RTL and testbench
==============================

# sync_mem_be

Parametrised synchronous 1-read/1-write data memory for the RISC-V datapath, supporting byte-enabled stores, configurable read latency and valid-tagged read data. It keeps same-cycle write-to-read forwarding and adds per-byte merging. An optional hardware clear sweep zeroes the array after reset, and a `ready` flag gates the core's load/store unit until the sweep finishes. The block sits between the load/store unit and the register-file writeback path.

## Interface
- `ADDR_WIDTH`, default 10: address bits; depth = 1<<ADDR_WIDTH words.
- `DATA_WIDTH`, default 32: word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
- `READ_LATENCY`, default 1: edges from read accept to data; legal range 1..4.
- `CLEAR_ON_RESET`, default 1: 1 = zero the whole array after reset; 0 = contents preserved.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `ready`  out  1  high when reads and writes are accepted.
- `re`  in  1  read request.
- `ra`  in  ADDR_WIDTH  read address.
- `we`  in  1  write request.
- `wa`  in  ADDR_WIDTH  write address.
- `wd`  in  DATA_WIDTH  write data.
- `wstrb`  in  NB  byte write enables; bit i controls `wd[8i+7:8i]`.
- `rd`  out  DATA_WIDTH  read data.
- `rd_valid`  out  1  `rd` holds a new response this cycle.

## Operation
- FSM states:
  - RESET: entered on any edge with `rst`=1.
  - CLEAR: sweep counter `clr_addr`.
  - RUN.
- Transitions:
  - RESET -> CLEAR on the first edge with `rst`=0, if CLEAR_ON_RESET=1.
  - RESET -> RUN on the first edge with `rst`=0, if CLEAR_ON_RESET=0.
  - CLEAR -> RUN after the edge that writes address DEPTH-1.
- Reset values, applied on the `rst` edge: `rd`=0, `rd_valid`=0, `ready`=0, `clr_addr`=0, all read-pipeline valid bits 0.
- CLEAR:
  - Each edge writes 0 to `mem[clr_addr]` and increments `clr_addr`.
  - `clr_addr` wraps to 0 after DEPTH-1; the sweep has no early exit.
- `ready`=1 only in RUN. While `ready`=0, `re`, `we` and `wstrb` are ignored: no array write, no response.
- Write, on an edge in RUN with `we`=1: for each i with `wstrb[i]`=1, byte i of `mem[wa]` <= byte i of `wd`. Other bytes are unchanged. `wstrb`=0 is a legal no-op.
- Read accept, on an edge in RUN with `re`=1: the word is sampled at that edge and enters the read pipeline.
- Forwarding: if `we`&`re`&(`ra`==`wa`) on the same edge, the sampled word is built per byte:
  - bytes with `wstrb[i]`=1 take `wd`;
  - other bytes take the old `mem` contents.
- A read's data is fixed at its accept edge; writes on later edges never alter an in-flight response.
- `rd` holds its last value when `rd_valid`=0; only reset zeroes it.
- Reset mid-operation:
  - in-flight reads are dropped, with no `rd_valid` for them;
  - a write presented on a `rst` edge is dropped;
  - array contents are re-cleared if CLEAR_ON_RESET=1, else retained.

## Timing
- Read latency: a read accepted at edge T drives `rd`/`rd_valid`=1 after edge T+READ_LATENCY-1. With latency 1, data is visible in the cycle right after the accept edge.
- `rd_valid` is high for exactly one cycle per accepted read.
- Throughput: one read and one write per cycle, sustained, with no bubbles at any latency.
- Clear duration: with CLEAR_ON_RESET=1, `ready` rises after the DEPTH-th edge following `rst` deassertion (`ready`=1 for the first time in cycle DEPTH+1).
- No clear: with CLEAR_ON_RESET=0, `ready` rises after the first edge with `rst`=0.
- The first accepted read after `ready` rises returns cleared data (0) for any address not yet written.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Reset/clear: ADDR_WIDTH=4, CLEAR_ON_RESET=1, array preloaded with 32'hFFFFFFFF, `rst` pulsed.
  - Required: `ready`=0 for 16 cycles, then 1.
  - Required: reading addresses 0..15 returns 0.
  - Required: no `rd_valid` while `ready`=0, even with `re` held high.
- Byte strobes:
  - Stimulus: write 32'h11223344 with `wstrb`=4'hF to addr 3, then 32'hAABBCCDD with `wstrb`=4'b0101.
  - Required: reading addr 3 returns 32'h11BB33DD.
- Forwarding:
  - Setup: mem[5]=32'h01020304.
  - Stimulus: on the same edge, `re`/`ra`=5 and `we`/`wa`=5/`wd`=32'hA0B0C0D0/`wstrb`=4'b0011.
  - Required: `rd`=32'h0102C0D0.
  - Required: a subsequent read of addr 5 returns the same value.
- Latency sweep: READ_LATENCY=1..4, back-to-back reads of addresses 0..7 holding value = address.
  - Required: `rd_valid` high for 8 consecutive cycles, starting READ_LATENCY-1 edges after the first accept.
  - Required: data in address order.
- In-flight isolation and reset abort: READ_LATENCY=3.
  - Stimulus: read addr 2 (value 7), write 9 to addr 2 on the next edge.
  - Required: the response is 7.
  - Stimulus: assert `rst` while a read is in flight.
  - Required: no `rd_valid`; `rd`=0 after the reset edge.
- CLEAR_ON_RESET=0:
  - Stimulus: write 32'hACDC1234 to addr 9, pulse `rst`.
  - Required: `ready`=1 after one edge.
  - Required: reading addr 9 returns 32'hACDC1234.

Source files
------------

// File: rtl/sync_mem_be_if.sv
// Load/store bus between the core's LSU (master) and the byte-enabled data memory (slave).
interface sync_mem_be_if #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned NB = DATA_WIDTH / 8;

   logic                  ready;
   logic                  re;
   logic [ADDR_WIDTH-1:0] ra;
   logic                  we;
   logic [ADDR_WIDTH-1:0] wa;
   logic [DATA_WIDTH-1:0] wd;
   logic [NB-1:0]         wstrb;
   logic [DATA_WIDTH-1:0] rd;
   logic                  rd_valid;

   modport master (input ready, rd, rd_valid, output re, ra, we, wa, wd, wstrb);
   modport slave  (output ready, rd, rd_valid, input re, ra, we, wa, wd, wstrb);
endinterface

// File: rtl/sync_mem_be.sv
// 1R/1W synchronous data memory with byte strobes, write-to-read forwarding,
// a READ_LATENCY-deep valid-tagged read pipeline and an optional post-reset clear sweep.
module sync_mem_be #(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic            clk,
   input  logic            rst,
   sync_mem_be_if.slave    bus
);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned NB    = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {S_RESET, S_CLEAR, S_RUN} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
   logic                  clr_we_c;
   logic                  ready_q;
   logic                  wr_en_c, rd_en_c;
   logic [DATA_WIDTH-1:0] rd_word_c;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
   logic [READ_LATENCY-1:0] pipe_vld_q;

   // The edge leaving RESET already clears address 0, so the sweep takes exactly DEPTH edges.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_we_c   = 1'b0;
      unique case (state_q)
         S_RESET, S_CLEAR: begin
            if (state_q == S_CLEAR || CLEAR_ON_RESET != 0) begin
               clr_we_c   = 1'b1;
               clr_addr_d = clr_addr_q + 1'b1;
               state_d    = (clr_addr_q == LAST_ADDR) ? S_RUN : S_CLEAR;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN:   state_d = S_RUN;
         default: state_d = S_RESET;
      endcase
      if (rst) clr_we_c = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_RESET;
         clr_addr_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         ready_q    <= (state_d == S_RUN);
      end
   end

   assign wr_en_c = ready_q & bus.we & ~rst;
   assign rd_en_c = ready_q & bus.re & ~rst;

   // Array has no reset so contents survive when the clear sweep is disabled.
   always_ff @(posedge clk) begin
      if (clr_we_c) begin
         mem_q[clr_addr_q] <= '0;
      end else if (wr_en_c) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (bus.wstrb[i]) mem_q[bus.wa][8*i +: 8] <= bus.wd[8*i +: 8];
         end
      end
   end

   // Same-edge write to the read address is merged byte by byte.
   always_comb begin
      rd_word_c = mem_q[bus.ra];
      for (int unsigned i = 0; i < NB; i++) begin
         if (wr_en_c && bus.wa == bus.ra && bus.wstrb[i]) rd_word_c[8*i +: 8] = bus.wd[8*i +: 8];
      end
   end

   // Data stages only load behind a valid, so the last stage holds rd between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld_q <= '0;
         for (int unsigned k = 0; k < READ_LATENCY; k++) pipe_data_q[k] <= '0;
      end else begin
         pipe_vld_q[0] <= rd_en_c;
         if (rd_en_c) pipe_data_q[0] <= rd_word_c;
         for (int unsigned k = 1; k < READ_LATENCY; k++) begin
            pipe_vld_q[k] <= pipe_vld_q[k-1];
            if (pipe_vld_q[k-1]) pipe_data_q[k] <= pipe_data_q[k-1];
         end
      end
   end

   assign bus.ready    = ready_q;
   assign bus.rd       = pipe_data_q[READ_LATENCY-1];
   assign bus.rd_valid = pipe_vld_q[READ_LATENCY-1];
endmodule

// File: tb/tb_sync_mem_be.sv
// Four cleared-on-reset instances (latency 1..4) share one stimulus and one reference model;
// a fifth instance without clear checks content retention across reset.
module tb_sync_mem_be;
   localparam int unsigned AW = 4, DW = 32, NB = 4, DEPTH = 16, NLAT = 4, HN = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, re, we, rst0;
   logic [AW-1:0] ra, wa;
   logic [DW-1:0] wd;
   logic [NB-1:0] wstrb;

   logic [DW-1:0] rd_a  [NLAT];
   logic          rdv_a [NLAT];
   logic          rdy_a [NLAT];

   for (genvar g = 0; g < NLAT; g++) begin : g_dut
      sync_mem_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
      assign bus.re = re;
      assign bus.ra = ra;
      assign bus.we = we;
      assign bus.wa = wa;
      assign bus.wd = wd;
      assign bus.wstrb = wstrb;
      assign rd_a[g]  = bus.rd;
      assign rdv_a[g] = bus.rd_valid;
      assign rdy_a[g] = bus.ready;
      sync_mem_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(g + 1), .CLEAR_ON_RESET(1))
         u_dut (.clk(clk), .rst(rst), .bus(bus));
   end

   sync_mem_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
   sync_mem_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .CLEAR_ON_RESET(0))
      u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));

   // Reference model: word array, per-edge accepted-read history, per-latency held rd.
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_ready;
   int            clr_cnt, n, last_rst;
   bit            hv [HN];
   logic [DW-1:0] hd [HN];
   logic [DW-1:0] exp_rd [NLAT];
   int            checks, errors;

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [NB-1:0] ws;
      logic          re;
      logic [AW-1:0] ra;
      logic          chk;
      logic [DW-1:0] exp;
   } vec_t;

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      logic r_rst, r_re, r_we;
      logic [AW-1:0] r_ra, r_wa;
      logic [DW-1:0] r_wd;
      logic [NB-1:0] r_ws;
      int k;
      bit v;
      r_rst = rst; r_re = re; r_we = we; r_ra = ra; r_wa = wa; r_wd = wd; r_ws = wstrb;
      @(posedge clk);
      #1;
      n++;
      if (n >= HN) begin
         $display("FAIL history_overflow: got %0d expected below %0d", n, HN);
         $fatal(1, "history overflow");
      end
      hv[n] = 1'b0;
      hd[n] = '0;
      if (r_rst) begin
         m_ready = 1'b0;
         clr_cnt = 0;
         last_rst = n;
         foreach (m_mem[i]) m_mem[i] = '0;
         foreach (exp_rd[i]) exp_rd[i] = '0;
      end else if (!m_ready) begin
         clr_cnt++;
         if (clr_cnt == DEPTH) m_ready = 1'b1;
      end else begin
         if (r_we)
            for (int b = 0; b < NB; b++)
               if (r_ws[b]) m_mem[r_wa][8*b +: 8] = r_wd[8*b +: 8];
         // The response equals the array word as it stands after this edge's write.
         if (r_re) begin
            hv[n] = 1'b1;
            hd[n] = m_mem[r_ra];
         end
      end
      for (int L = 0; L < NLAT; L++) begin
         k = n - L;
         v = (k >= 1) && (k > last_rst) && hv[k];
         if (v) exp_rd[L] = hd[k];
         check($sformatf("ready_L%0d", L + 1), DW'(rdy_a[L]), DW'(m_ready));
         check($sformatf("rd_valid_L%0d", L + 1), DW'(rdv_a[L]), DW'(v));
         check($sformatf("rd_L%0d", L + 1), rd_a[L], exp_rd[L]);
      end
   endtask

   task automatic wait_ready(input string nm, input int expect_edges);
      int ecnt;
      ecnt = 0;
      for (int i = 0; i < 3 * DEPTH && rdy_a[0] !== 1'b1; i++) begin
         tick();
         ecnt++;
      end
      check(nm, DW'(ecnt), DW'(expect_edges));
   endtask

   vec_t vt [8];
   int   vcnt [NLAT];

   initial begin
      vt[0] = '{1'b1, 4'd3,  32'h11223344, 4'hF,    1'b0, 4'd0,  1'b0, 32'h0};
      vt[1] = '{1'b1, 4'd3,  32'hAABBCCDD, 4'b0101, 1'b0, 4'd0,  1'b0, 32'h0};
      vt[2] = '{1'b0, 4'd0,  32'h0,        4'h0,    1'b1, 4'd3,  1'b1, 32'h11BB33DD};
      vt[3] = '{1'b1, 4'd5,  32'h01020304, 4'hF,    1'b0, 4'd0,  1'b0, 32'h0};
      vt[4] = '{1'b1, 4'd5,  32'hA0B0C0D0, 4'b0011, 1'b1, 4'd5,  1'b1, 32'h0102C0D0};
      vt[5] = '{1'b0, 4'd0,  32'h0,        4'h0,    1'b1, 4'd5,  1'b1, 32'h0102C0D0};
      vt[6] = '{1'b1, 4'd5,  32'hFFFFFFFF, 4'h0,    1'b1, 4'd5,  1'b1, 32'h0102C0D0};
      vt[7] = '{1'b1, 4'd15, 32'hDEADBEEF, 4'b1000, 1'b1, 4'd15, 1'b1, 32'hDE000000};

      checks = 0; errors = 0; n = 0; last_rst = 0; m_ready = 1'b0; clr_cnt = 0;
      foreach (hv[i]) hv[i] = 1'b0;
      foreach (exp_rd[i]) exp_rd[i] = '0;
      rst = 1'b1; re = 1'b0; we = 1'b0; ra = '0; wa = '0; wd = '0; wstrb = '0;
      rst0 = 1'b1;
      bus0.re = 1'b0; bus0.ra = '0; bus0.we = 1'b0; bus0.wa = '0; bus0.wd = '0; bus0.wstrb = '0;
      tick(); tick();

      // Initial clear with a read held high; the no-clear instance is ready after one edge.
      rst = 1'b0; rst0 = 1'b0; re = 1'b1; ra = 4'd3;
      tick();
      check("noclr_ready_first_edge", DW'(bus0.ready), 32'd1);
      wait_ready("clear_edges_initial", DEPTH - 1);
      re = 1'b0;

      // Fill with ones, then reset: the sweep must zero every word again.
      for (int a = 0; a < DEPTH; a++) begin
         we = 1'b1; wa = AW'(a); wd = 32'hFFFFFFFF; wstrb = 4'hF;
         tick();
      end
      we = 1'b0; re = 1'b1; ra = 4'd7;
      tick();
      rst = 1'b1; ra = 4'd9;
      tick();
      rst = 1'b0;
      wait_ready("clear_edges_reclear", DEPTH);
      for (int a = 0; a < DEPTH; a++) begin
         ra = AW'(a);
         tick();
      end
      re = 1'b0;
      repeat (4) tick();

      // Byte strobes and forwarding table.
      foreach (vt[i]) begin
         we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd; wstrb = vt[i].ws;
         re = vt[i].re; ra = vt[i].ra;
         tick();
         if (vt[i].chk) begin
            check($sformatf("vec%0d_rd", i), rd_a[0], vt[i].exp);
            check($sformatf("vec%0d_valid", i), DW'(rdv_a[0]), 32'd1);
         end
      end
      we = 1'b0; re = 1'b0;
      repeat (4) tick();

      // Latency sweep: eight back-to-back reads give eight valids on every instance.
      for (int a = 0; a < 8; a++) begin
         we = 1'b1; wa = AW'(a); wd = DW'(a); wstrb = 4'hF;
         tick();
      end
      we = 1'b0;
      foreach (vcnt[i]) vcnt[i] = 0;
      for (int a = 0; a < 12; a++) begin
         re = (a < 8); ra = AW'(a);
         tick();
         for (int L = 0; L < NLAT; L++) vcnt[L] += int'(rdv_a[L]);
      end
      re = 1'b0;
      for (int L = 0; L < NLAT; L++) check($sformatf("burst_count_L%0d", L + 1), DW'(vcnt[L]), 32'd8);

      // In-flight isolation at latency 3.
      we = 1'b1; wa = 4'd2; wd = 32'd7; wstrb = 4'hF;
      tick();
      we = 1'b0; re = 1'b1; ra = 4'd2;
      tick();
      re = 1'b0; we = 1'b1; wd = 32'd9;
      tick();
      we = 1'b0;
      tick();
      check("inflight_rd_L3", rd_a[2], 32'd7);
      check("inflight_valid_L3", DW'(rdv_a[2]), 32'd1);

      // Reset while a read is in flight.
      re = 1'b1; ra = 4'd2;
      tick();
      re = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_rd_L3", rd_a[2], 32'd0);
      check("abort_valid_L3", DW'(rdv_a[2]), 32'd0);
      tick();
      check("abort_no_late_valid_L3", DW'(rdv_a[2]), 32'd0);
      wait_ready("clear_edges_abort", DEPTH - 1);

      // Random traffic with occasional resets.
      for (int i = 0; i < 500; i++) begin
         re = 1'($urandom); ra = AW'($urandom); we = 1'($urandom); wa = AW'($urandom);
         wd = $urandom; wstrb = NB'($urandom);
         if ($urandom_range(0, 3) == 0) ra = wa;
         rst = ($urandom_range(0, 149) == 0);
         tick();
      end
      rst = 1'b0; re = 1'b0; we = 1'b0;
      repeat (2 * DEPTH) tick();
      check("random_ready_back", DW'(rdy_a[0]), 32'd1);

      // No-clear instance keeps contents across reset; a write on the reset edge is dropped.
      bus0.we = 1'b1; bus0.wa = 4'd9; bus0.wd = 32'hACDC1234; bus0.wstrb = 4'hF;
      tick();
      rst0 = 1'b1; bus0.wd = 32'h0;
      tick();
      check("noclr_ready_in_reset", DW'(bus0.ready), 32'd0);
      check("noclr_rd_reset", bus0.rd, 32'd0);
      rst0 = 1'b0; bus0.we = 1'b0;
      tick();
      check("noclr_ready_after_reset", DW'(bus0.ready), 32'd1);
      bus0.re = 1'b1; bus0.ra = 4'd9;
      tick();
      bus0.re = 1'b0;
      check("noclr_valid_early", DW'(bus0.rd_valid), 32'd0);
      tick();
      check("noclr_valid", DW'(bus0.rd_valid), 32'd1);
      check("noclr_rd", bus0.rd, 32'hACDC1234);
      tick();
      check("noclr_valid_single", DW'(bus0.rd_valid), 32'd0);
      check("noclr_rd_hold", bus0.rd, 32'hACDC1234);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
